// File: rtl/alu_muldiv_seq_pkg.sv
// Shared encodings for the multi-cycle MUL/DIV sequencer: operation codes,
// FSM states and the two ALU opcodes the sequencer issues.
package alu_muldiv_seq_pkg;

   localparam int unsigned ALU_OP_DEF_W = 6;

   localparam logic [ALU_OP_DEF_W-1:0] ADD_OP = 6'd0;
   localparam logic [ALU_OP_DEF_W-1:0] SUB_OP = 6'd1;

   typedef enum logic [1:0] {
      MD_MUL   = 2'b00,
      MD_MULHU = 2'b01,
      MD_DIVU  = 2'b10,
      MD_REMU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      MDS_IDLE = 2'b00,
      MDS_RUN  = 2'b01,
      MDS_DONE = 2'b10
   } md_state_e;

   function automatic logic md_is_div(md_op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Pipeline-side request/response bundle of the MUL/DIV sequencer.
// master: the EX stage issuing ops; slave: the sequencer.
interface alu_muldiv_seq_if #(
   parameter int unsigned XLEN = 32
);
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] opr_a;
   logic [XLEN-1:0] opr_b;
   logic            kill;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] res;

   modport master (
      output start, op, opr_a, opr_b, kill,
      input  busy, done, res
   );

   modport slave (
      input  start, op, opr_a, opr_b, kill,
      output busy, done, res
   );
endinterface

// File: rtl/alu_muldiv_seq_muldiv_step.sv
// One shift-add (multiply) or restoring shift-subtract (divide) iteration.
// The ALU does the 32-bit add/sub; carry and compare are resolved here.
module muldiv_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic            is_div_i,
   input  logic [XLEN-1:0] acc_i,      // hi (mul) / rem (div)
   input  logic [XLEN-1:0] lo_i,       // lo (mul) / quo (div)
   input  logic [XLEN-1:0] opnd_i,     // mcand (mul) / dvsr (div)
   input  logic [XLEN-1:0] alu_res_i,
   output logic [XLEN-1:0] alu_a_o,
   output logic [XLEN-1:0] alu_b_o,
   output logic [XLEN-1:0] acc_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0] s;
   logic          carry;
   logic          ge;

   assign s     = {acc_i, lo_i[XLEN-1]};
   assign carry = (alu_res_i < acc_i);
   // A set top bit of S means S exceeds any XLEN-bit divisor.
   assign ge    = s[XLEN] | (s[XLEN-1:0] >= opnd_i);

   always_comb begin
      alu_a_o = '0;
      alu_b_o = '0;
      acc_o   = acc_i;
      lo_o    = lo_i;
      if (is_div_i) begin
         alu_a_o = s[XLEN-1:0];
         alu_b_o = opnd_i;
         acc_o   = ge ? alu_res_i : s[XLEN-1:0];
         lo_o    = {lo_i[XLEN-2:0], ge};
      end else begin
         alu_a_o = acc_i;
         alu_b_o = lo_i[0] ? opnd_i : '0;
         acc_o   = {carry, alu_res_i[XLEN-1:1]};
         lo_o    = {alu_res_i[0], lo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the EX-stage
// ALU for one add or subtract per cycle; XLEN iterations per operation.
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ALU_OP_W = 6,
   parameter int unsigned CNT_W    = 6
) (
   input  logic                clk,
   input  logic                reset,
   alu_muldiv_seq_if.slave     md,
   output logic                alu_req_o,
   output logic [XLEN-1:0]     alu_opr_a_o,
   output logic [XLEN-1:0]     alu_opr_b_o,
   output logic [ALU_OP_W-1:0] alu_op_o,
   input  logic [XLEN-1:0]     alu_res_i
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(XLEN - 1);

   md_state_e       state_q, state_d;
   md_op_e          op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] opnd_q, opnd_d;
   logic [XLEN-1:0] res_q, res_d;

   logic            run;
   logic            is_div;
   logic            new_div;
   logic [XLEN-1:0] step_a, step_b, step_acc, step_lo;

   assign run     = (state_q == MDS_RUN);
   assign is_div  = md_is_div(op_q);
   assign new_div = md_is_div(md_op_e'(md.op));

   muldiv_step #(
      .XLEN (XLEN)
   ) u_step (
      .is_div_i  (is_div),
      .acc_i     (acc_q),
      .lo_i      (lo_q),
      .opnd_i    (opnd_q),
      .alu_res_i (alu_res_i),
      .alu_a_o   (step_a),
      .alu_b_o   (step_b),
      .acc_o     (step_acc),
      .lo_o      (step_lo)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      opnd_d  = opnd_q;
      res_d   = res_q;
      unique case (state_q)
         MDS_IDLE: begin
            if (md.start && !md.kill) begin
               state_d = MDS_RUN;
               op_d    = md_op_e'(md.op);
               cnt_d   = '0;
               acc_d   = '0;
               lo_d    = new_div ? md.opr_a : md.opr_b;
               opnd_d  = new_div ? md.opr_b : md.opr_a;
            end
         end
         MDS_RUN: begin
            if (md.kill) begin
               state_d = MDS_IDLE;
            end else begin
               acc_d = step_acc;
               lo_d  = step_lo;
               if (cnt_q == LastCnt) begin
                  state_d = MDS_DONE;
                  unique case (op_q)
                     MD_MUL:   res_d = step_lo;
                     MD_MULHU: res_d = step_acc;
                     MD_DIVU:  res_d = step_lo;
                     MD_REMU:  res_d = step_acc;
                     default:  res_d = res_q;
                  endcase
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         MDS_DONE: state_d = MDS_IDLE;
         default:  state_d = MDS_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= MDS_IDLE;
         op_q    <= MD_MUL;
         cnt_q   <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         opnd_q  <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         opnd_q  <= opnd_d;
         res_q   <= res_d;
      end
   end

   // A kill arriving during DONE swallows the completion pulse.
   assign md.done = (state_q == MDS_DONE) && !md.kill;
   assign md.busy = (state_q != MDS_IDLE);
   assign md.res  = res_q;

   assign alu_req_o   = run;
   assign alu_opr_a_o = run ? step_a : '0;
   assign alu_opr_b_o = run ? step_b : '0;
   assign alu_op_o    = (run && is_div) ? ALU_OP_W'(SUB_OP) : ALU_OP_W'(ADD_OP);

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural add/sub ALU beside it.
module tb_alu_muldiv_seq;
   import alu_muldiv_seq_pkg::*;

   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            alu_req;
   logic [XLEN-1:0] alu_a, alu_b, alu_res;
   logic [5:0]      alu_op;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_muldiv_seq_if #(.XLEN(XLEN)) mif ();

   alu_muldiv_seq #(
      .XLEN     (XLEN),
      .ALU_OP_W (6),
      .CNT_W    (6)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .md          (mif.slave),
      .alu_req_o   (alu_req),
      .alu_opr_a_o (alu_a),
      .alu_opr_b_o (alu_b),
      .alu_op_o    (alu_op),
      .alu_res_i   (alu_res)
   );

   assign alu_res = (alu_op == SUB_OP) ? (alu_a - alu_b) : (alu_a + alu_b);

   // Returns in cycle 1 (one #1 after the accepting edge).
   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      mif.start = 1'b1;
      mif.op    = op;
      mif.opr_a = a;
      mif.opr_b = b;
      @(posedge clk);
      #1;
      mif.start = 1'b0;
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int done_cyc);
      launch(op, a, b);
      done_cyc = 0;
      res      = 'x;
      for (int c = 1; c <= 40; c++) begin
         if (mif.done) begin
            done_cyc = c;
            res      = mif.res;
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      tests++;
      if ({mif.busy, mif.done, alu_req} !== 3'b000) begin
         fails++;
         $display("FAIL reset_flags got busy/done/req=%b want 000", {mif.busy, mif.done, alu_req});
      end
      tests++;
      if (mif.res !== 32'h0 || alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== ADD_OP) begin
         fails++;
         $display("FAIL reset_data got res=%h a=%h b=%h op=%h want 0/0/0/%h",
                  mif.res, alu_a, alu_b, alu_op, ADD_OP);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_mul_latency();
      int first_req = 0, req_n = 0, busy_n = 0, done_cyc = 0;
      logic [31:0] res = '0, a2 = '0, b2 = '0;
      launch(MD_MUL, 32'd7, 32'd6);
      for (int c = 1; c <= 36; c++) begin
         if (alu_req) begin
            req_n++;
            if (first_req == 0) first_req = c;
         end
         if (mif.busy) busy_n++;
         if (c == 2) begin
            a2 = alu_a;
            b2 = alu_b;
         end
         if (mif.done && done_cyc == 0) begin
            done_cyc = c;
            res      = mif.res;
         end
         @(posedge clk);
         #1;
      end
      tests++;
      if (first_req != 1 || req_n != 32) begin
         fails++;
         $display("FAIL mul_req_window got first=%0d n=%0d want 1/32", first_req, req_n);
      end
      tests++;
      if (busy_n != 33 || done_cyc != 33) begin
         fails++;
         $display("FAIL mul_busy_done got busy=%0d done_cyc=%0d want 33/33", busy_n, done_cyc);
      end
      tests++;
      if (res !== 32'h2A) begin
         fails++;
         $display("FAIL mul_7x6 got %h want 0000002a", res);
      end
      tests++;
      if (a2 !== 32'h0 || b2 !== 32'd7) begin
         fails++;
         $display("FAIL mul_cycle2_operands got a=%h b=%h want 0/7", a2, b2);
      end
      tests++;
      if (alu_req !== 1'b0 || alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== ADD_OP) begin
         fails++;
         $display("FAIL idle_alu_drive got req=%b a=%h b=%h op=%h", alu_req, alu_a, alu_b, alu_op);
      end
   endtask

   task automatic test_mul_carry();
      logic [31:0] res;
      int          dc;
      run_op(MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, dc);
      tests++;
      if (dc != 33 || res !== 32'h0000_0001) begin
         fails++;
         $display("FAIL mul_ffff got %h cyc %0d want 00000001 cyc 33", res, dc);
      end
      run_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, dc);
      tests++;
      if (dc != 33 || res !== 32'hFFFF_FFFE) begin
         fails++;
         $display("FAIL mulhu_ffff got %h cyc %0d want fffffffe cyc 33", res, dc);
      end
   endtask

   task automatic test_div();
      logic [31:0] res;
      int          dc;
      launch(MD_DIVU, 32'd100, 32'd7);
      tests++;
      if (alu_req !== 1'b1 || alu_op !== SUB_OP || alu_a !== 32'h0 || alu_b !== 32'd7) begin
         fails++;
         $display("FAIL div_cycle1_alu got req=%b op=%h a=%h b=%h want 1/%h/0/7",
                  alu_req, alu_op, alu_a, alu_b, SUB_OP);
      end
      for (int c = 1; c <= 40 && !mif.done; c++) begin
         @(posedge clk);
         #1;
      end
      tests++;
      if (mif.res !== 32'h0000_000E) begin
         fails++;
         $display("FAIL divu_100_7 got %h want 0000000e", mif.res);
      end
      @(posedge clk);
      #1;
      run_op(MD_REMU, 32'd100, 32'd7, res, dc);
      tests++;
      if (dc != 33 || res !== 32'h0000_0002) begin
         fails++;
         $display("FAIL remu_100_7 got %h cyc %0d want 00000002 cyc 33", res, dc);
      end
      run_op(MD_DIVU, 32'h8000_0000, 32'd2, res, dc);
      tests++;
      if (dc != 33 || res !== 32'h4000_0000) begin
         fails++;
         $display("FAIL divu_msb got %h cyc %0d want 40000000 cyc 33", res, dc);
      end
   endtask

   task automatic test_div_zero();
      logic [31:0] res;
      int          dc;
      run_op(MD_DIVU, 32'h1234, 32'h0, res, dc);
      tests++;
      if (dc != 33 || res !== 32'hFFFF_FFFF) begin
         fails++;
         $display("FAIL divu_by_zero got %h cyc %0d want ffffffff cyc 33", res, dc);
      end
      run_op(MD_REMU, 32'h1234, 32'h0, res, dc);
      tests++;
      if (dc != 33 || res !== 32'h0000_1234) begin
         fails++;
         $display("FAIL remu_by_zero got %h cyc %0d want 00001234 cyc 33", res, dc);
      end
   endtask

   task automatic test_kill();
      logic [31:0] res;
      int          dc, done_n, busy_n;
      run_op(MD_MUL, 32'd3, 32'd4, res, dc);
      tests++;
      if (res !== 32'd12) begin
         fails++;
         $display("FAIL kill_setup got %h want 0000000c", res);
      end
      launch(MD_DIVU, 32'd100, 32'd7);
      for (int c = 1; c < 10; c++) begin
         @(posedge clk);
         #1;
      end
      mif.kill = 1'b1;
      @(posedge clk);
      #1;
      mif.kill = 1'b0;
      tests++;
      if (mif.busy !== 1'b0 || alu_req !== 1'b0) begin
         fails++;
         $display("FAIL kill_to_idle got busy=%b req=%b want 0/0", mif.busy, alu_req);
      end
      done_n = 0;
      for (int c = 0; c < 40; c++) begin
         if (mif.done) done_n++;
         @(posedge clk);
         #1;
      end
      tests++;
      if (done_n != 0 || mif.res !== 32'd12) begin
         fails++;
         $display("FAIL kill_no_result got dones=%0d res=%h want 0/0000000c", done_n, mif.res);
      end

      // A start pulse mid-run must neither disturb nor queue behind the MUL.
      launch(MD_MUL, 32'd7, 32'd6);
      dc = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 5) begin
            mif.start = 1'b1;
            mif.op    = MD_DIVU;
            mif.opr_a = 32'd100;
            mif.opr_b = 32'd7;
         end
         if (c == 6) mif.start = 1'b0;
         if (mif.done && dc == 0) begin
            dc  = c;
            res = mif.res;
         end
         @(posedge clk);
         #1;
      end
      tests++;
      if (dc != 33 || res !== 32'h2A) begin
         fails++;
         $display("FAIL start_while_busy got %h cyc %0d want 0000002a cyc 33", res, dc);
      end
      tests++;
      if (mif.busy !== 1'b0) begin
         fails++;
         $display("FAIL start_not_queued got busy=%b want 0", mif.busy);
      end

      @(negedge clk);
      mif.start = 1'b1;
      mif.kill  = 1'b1;
      mif.op    = MD_MUL;
      mif.opr_a = 32'd3;
      mif.opr_b = 32'd5;
      @(posedge clk);
      #1;
      mif.start = 1'b0;
      mif.kill  = 1'b0;
      busy_n = 0;
      done_n = 0;
      for (int c = 0; c < 40; c++) begin
         if (mif.busy) busy_n++;
         if (mif.done) done_n++;
         @(posedge clk);
         #1;
      end
      tests++;
      if (busy_n != 0 || done_n != 0 || mif.res !== 32'h2A) begin
         fails++;
         $display("FAIL start_kill_idle got busy=%0d done=%0d res=%h want 0/0/0000002a",
                  busy_n, done_n, mif.res);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] res;
      int          dc;
      launch(MD_MUL, 32'd9, 32'd9);
      for (int c = 1; c < 10; c++) begin
         @(posedge clk);
         #1;
      end
      #2;
      reset = 1'b1;
      #1;
      tests++;
      if ({mif.busy, mif.done, alu_req} !== 3'b000 || mif.res !== 32'h0) begin
         fails++;
         $display("FAIL async_reset got busy/done/req=%b res=%h want 000/0",
                  {mif.busy, mif.done, alu_req}, mif.res);
      end
      @(negedge clk);
      reset = 1'b0;
      run_op(MD_MUL, 32'd3, 32'd5, res, dc);
      tests++;
      if (dc != 33 || res !== 32'h0000_000F) begin
         fails++;
         $display("FAIL post_reset_mul got %h cyc %0d want 0000000f cyc 33", res, dc);
      end
   endtask

   initial begin
      mif.start = 1'b0;
      mif.kill  = 1'b0;
      mif.op    = 2'b00;
      mif.opr_a = '0;
      mif.opr_b = '0;
      test_reset();
      test_mul_latency();
      test_mul_carry();
      test_div();
      test_div_zero();
      test_kill();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
